// File: rtl/cache_read_ctrl_if.sv
// Bus bundle for cache_read_ctrl: CPU-side Avalon-MM read slave, memory-side burst master, flush strobe.
// The slave modport is the controller's view; master is the environment's view.
interface cache_read_ctrl_if #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LOG_WORDS = 2
);
  logic [ADDR_W-1:0]  s_address;
  logic               s_read;
  logic               s_waitrequest;
  logic [DATA_W-1:0]  s_readdata;
  logic               flush;
  logic [ADDR_W-1:0]  m_address;
  logic               m_read;
  logic [LOG_WORDS:0] m_burstcount;
  logic               m_waitrequest;
  logic [DATA_W-1:0]  m_readdata;
  logic               m_readdatavalid;

  modport slave (
    input  s_address, s_read, flush, m_waitrequest, m_readdata, m_readdatavalid,
    output s_waitrequest, s_readdata, m_address, m_read, m_burstcount
  );

  modport master (
    output s_address, s_read, flush, m_waitrequest, m_readdata, m_readdatavalid,
    input  s_waitrequest, s_readdata, m_address, m_read, m_burstcount
  );
endinterface

// File: rtl/cache_read_ctrl.sv
// Read-only set-associative cache controller: tag match across all ways, round-robin
// replacement once a set is full, and line refill over an Avalon-MM burst.
//
// state       | meaning
// IDLE        | service a pending flush, else accept a CPU read
// LOOKUP      | tag compare; hit answers this cycle, miss picks a victim
// REFILL_REQ  | burst command held until memory accepts it
// REFILL_DATA | write incoming beats into the victim line
// RESPOND     | return the captured word
module cache_read_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int WAYS      = 4,
  parameter int LOG_WAYS  = 2,
  parameter int LOG_SETS  = 4,
  parameter int LOG_WORDS = 2
) (
  input logic              clk,
  input logic              reset_n,
  cache_read_ctrl_if.slave bus
);
  localparam int TAG_W = ADDR_W - LOG_SETS - LOG_WORDS - 2;
  localparam int SETS  = 1 << LOG_SETS;
  localparam int WORDS = 1 << LOG_WORDS;
  localparam int OFF_W = LOG_WORDS + 2;
  localparam logic [LOG_WORDS-1:0] LAST_BEAT = LOG_WORDS'(WORDS - 1);
  localparam logic [LOG_WORDS:0]   BURST_LEN = (LOG_WORDS + 1)'(WORDS);

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, RESPOND} state_t;

  state_t               state;
  logic [ADDR_W-1:0]    addr_q;
  logic [TAG_W-1:0]     tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0]    data_mem [SETS][WAYS][WORDS];
  logic [WAYS-1:0]      valid    [SETS];
  logic [LOG_WAYS-1:0]  rr_ptr   [SETS];
  logic                 flush_pend;
  logic [LOG_WORDS-1:0] beat_cnt;
  logic [LOG_WAYS-1:0]  victim;
  logic [DATA_W-1:0]    resp_q;

  logic [TAG_W-1:0]     tag;
  logic [LOG_SETS-1:0]  idx;
  logic [LOG_WORDS-1:0] word;
  logic                 unused_byte_off;

  assign tag             = addr_q[ADDR_W-1 -: TAG_W];
  assign idx             = addr_q[OFF_W +: LOG_SETS];
  assign word            = addr_q[2 +: LOG_WORDS];
  assign unused_byte_off = ^addr_q[1:0];

  logic [WAYS-1:0]     match;
  logic                hit;
  logic [LOG_WAYS-1:0] hit_way;
  logic [LOG_WAYS-1:0] free_way;
  logic                any_free;

  // free_way scans downward so the lowest-index invalid way wins
  always_comb begin
    match    = '0;
    hit_way  = '0;
    free_way = '0;
    any_free = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid[idx][w] && (tag_mem[idx][w] == tag);
      if (match[w]) hit_way = LOG_WAYS'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[idx][w]) begin
        free_way = LOG_WAYS'(w);
        any_free = 1'b1;
      end
    end
  end

  assign hit               = |match;
  assign bus.s_waitrequest = !((state == LOOKUP && hit) || state == RESPOND);
  assign bus.s_readdata    = (state == LOOKUP && hit) ? data_mem[idx][hit_way][word] : resp_q;
  assign bus.m_burstcount  = BURST_LEN;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      addr_q        <= '0;
      flush_pend    <= 1'b0;
      beat_cnt      <= '0;
      victim        <= '0;
      resp_q        <= '0;
      bus.m_read    <= 1'b0;
      bus.m_address <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s]  <= '0;
        rr_ptr[s] <= '0;
      end
    end else begin
      if (bus.flush && state != IDLE) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.flush || flush_pend) begin
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
            flush_pend <= 1'b0;
          end else if (bus.s_read) begin
            addr_q <= bus.s_address;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state <= IDLE;
          end else begin
            state         <= REFILL_REQ;
            bus.m_read    <= 1'b1;
            bus.m_address <= {tag, idx, {OFF_W{1'b0}}};
            if (any_free) begin
              victim <= free_way;
            end else begin
              victim      <= rr_ptr[idx];
              rr_ptr[idx] <= rr_ptr[idx] + LOG_WAYS'(1);
            end
          end
        end
        REFILL_REQ: begin
          if (!bus.m_waitrequest) begin
            bus.m_read <= 1'b0;
            beat_cnt   <= '0;
            state      <= REFILL_DATA;
          end
        end
        REFILL_DATA: begin
          if (bus.m_readdatavalid) begin
            beat_cnt <= beat_cnt + LOG_WORDS'(1);
            if (beat_cnt == word) resp_q <= bus.m_readdata;
            if (beat_cnt == LAST_BEAT) begin
              valid[idx][victim] <= 1'b1;
              state              <= RESPOND;
            end
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits alone decide what is live
  always_ff @(posedge clk) begin
    if (reset_n && state == REFILL_DATA && bus.m_readdatavalid) begin
      data_mem[idx][victim][beat_cnt] <= bus.m_readdata;
      if (beat_cnt == LAST_BEAT) tag_mem[idx][victim] <= tag;
    end
  end
endmodule

// File: tb/tb_cache_read_ctrl.sv
// Scoreboard bench for cache_read_ctrl: reads push expected words into a queue, a negedge
// monitor pops and compares on every completed read; a memory model answers refill bursts.
`timescale 1ns/1ps
module tb_cache_read_ctrl;
  localparam int HIT  = 0;
  localparam int MISS = 1;
  localparam int ANY  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cache_read_ctrl_if bus ();
  cache_read_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [$];
  int          bursts = 0;
  int          beats_sent = 0;
  int          mem_stall = 1;
  int          mem_lat = 1;
  int          beat_limit = 4;
  logic [31:0] last_cmd_addr = '0;

  // Line 0x100 holds A0..A3; everything else is derived from the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h10) return {24'h0, 4'hA, 2'b00, a[3:2]};
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.s_read && !bus.s_waitrequest) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_response: got 0x%08h expected no response", bus.s_readdata);
      end else begin
        check("readdata", bus.s_readdata, exp_q.pop_front());
      end
    end
    if (reset_n) begin
      n_assert++;
      if (!$onehot0(dut.match)) begin
        n_fail++;
        $display("FAIL multi_way_hit: got match=%b required at most one bit", dut.match);
      end
    end
  end

  // Memory model: optional command stalls, then latency, then up to beat_limit beats
  initial begin
    logic [31:0] cmd;
    bus.m_waitrequest   = 1'b1;
    bus.m_readdatavalid = 1'b0;
    bus.m_readdata      = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.m_read && reset_n) begin
        cmd = bus.m_address;
        repeat (mem_stall) begin
          bus.m_waitrequest = 1'b1;
          @(posedge clk); #1;
        end
        bus.m_waitrequest = 1'b0;
        check("m_address_stable", bus.m_address, cmd);
        check("m_burstcount", 32'(bus.m_burstcount), 32'd4);
        last_cmd_addr = bus.m_address;
        @(posedge clk); #1;
        bus.m_waitrequest = 1'b1;
        bursts++;
        repeat (mem_lat) begin
          @(posedge clk); #1;
        end
        for (int b = 0; b < 4 && b < beat_limit; b++) begin
          bus.m_readdata      = mem_word(cmd + 32'(b * 4));
          bus.m_readdatavalid = 1'b1;
          @(posedge clk); #1;
          beats_sent++;
        end
        bus.m_readdatavalid = 1'b0;
      end
    end
  end

  // Starts just after a rising edge and returns just after one
  task automatic cpu_read(input logic [31:0] a, input int kind, output int cycles);
    int b0;
    bit done;
    b0     = bursts;
    done   = 1'b0;
    cycles = 0;
    bus.s_address = a;
    bus.s_read    = 1'b1;
    exp_q.push_back(mem_word(a));
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (!bus.s_waitrequest) done = 1'b1;
    end
    @(posedge clk); #1;
    bus.s_read = 1'b0;
    if (!done) begin
      n_assert++;
      n_fail++;
      $display("FAIL read_timeout: got no completion for 0x%08h within 200 cycles", a);
      exp_q.delete();
    end
    if (kind == HIT) begin
      check("hit_latency", 32'(cycles), 32'd2);
      check("hit_no_burst", 32'(bursts - b0), 32'd0);
    end else if (kind == MISS) begin
      check("miss_burst", 32'(bursts - b0), 32'd1);
      check("refill_addr", last_cmd_addr, {a[31:4], 4'h0});
    end
  endtask

  task automatic idle_flush();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] fill_addr [13] = '{32'h000, 32'h404, 32'h808, 32'hC0C, 32'h1004, 32'h400,
                                  32'h008, 32'hC00, 32'h100C, 32'h408, 32'h80C, 32'h004, 32'hC04};
  int          fill_kind [13] = '{MISS, MISS, MISS, MISS, MISS, HIT,
                                  MISS, HIT, HIT, MISS, MISS, HIT, MISS};

  initial begin
    int  cyc;
    int  b0;
    bit  seen;
    logic [31:0] ra;
    bus.s_read    = 1'b0;
    bus.s_address = '0;
    bus.flush     = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_waitrequest", 32'(bus.s_waitrequest), 32'd1);
    check("rst_readdata", bus.s_readdata, 32'h0);
    check("rst_m_read", 32'(bus.m_read), 32'd0);
    check("rst_m_address", bus.m_address, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Cold miss with one command stall, then hits including back-to-back
    mem_stall = 1;
    cpu_read(32'h0000_0104, MISS, cyc);
    check("cold_refill_addr", last_cmd_addr, 32'h0000_0100);
    cpu_read(32'h0000_0108, HIT, cyc);
    cpu_read(32'h0000_010C, HIT, cyc);
    cpu_read(32'h0000_0100, HIT, cyc);

    // Flush during a refill beat: refill still answers, then everything is invalid
    seen = 1'b0;
    fork
      cpu_read(32'h0000_0204, MISS, cyc);
      begin
        for (int i = 0; i < 100 && !seen; i++) begin
          @(posedge clk); #2;
          if (bus.m_readdatavalid) seen = 1'b1;
        end
        if (seen) begin
          bus.flush = 1'b1;
          @(posedge clk); #1;
          bus.flush = 1'b0;
        end else begin
          n_assert++;
          n_fail++;
          $display("FAIL flush_beat_wait: got no refill beat within 100 cycles");
        end
      end
    join
    cpu_read(32'h0000_0204, MISS, cyc);
    cpu_read(32'h0000_0104, MISS, cyc);

    // Fill set 0 with five tags, then walk the round-robin pointer
    idle_flush();
    mem_stall = 0;
    for (int i = 0; i < 13; i++) cpu_read(fill_addr[i], fill_kind[i], cyc);

    // Reset after two beats of a refill
    mem_stall  = 0;
    beat_limit = 2;
    b0 = beats_sent;
    bus.s_address = 32'h0000_0354;
    bus.s_read    = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #2;
      if (beats_sent - b0 >= 2) seen = 1'b1;
    end
    if (!seen) begin
      n_assert++;
      n_fail++;
      $display("FAIL reset_beat_wait: got %0d beats, required 2", beats_sent - b0);
    end
    reset_n    = 1'b0;
    bus.s_read = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_m_read", 32'(bus.m_read), 32'd0);
    check("reset_waitrequest", 32'(bus.s_waitrequest), 32'd1);
    @(posedge clk); #1;
    beat_limit = 4;
    cpu_read(32'h0000_0354, MISS, cyc);
    cpu_read(32'h0000_0350, HIT, cyc);

    // Random stream over a small address pool so hits and evictions both occur
    for (int i = 0; i < 40; i++) begin
      mem_stall = $urandom_range(0, 2);
      mem_lat   = $urandom_range(0, 2);
      ra = {20'h0, 4'($urandom_range(0, 15)), 2'b00, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      cpu_read(ra, ANY, cyc);
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_read_ctrl.md
# cache_read_ctrl

Read-only, set-associative cache controller between a CPU-side Avalon-MM slave and a memory-side Avalon-MM burst master. It owns the tag, valid, data and round-robin replacement state. It performs a combinational tag match across all ways of the indexed set, and on a miss sequences a line refill burst. It returns the requested word to the CPU, then accepts the next request.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, word width (byte offset = 2 bits, fixed)
- WAYS, 4, associativity (power of two)
- LOG_WAYS, 2, log2(WAYS)
- LOG_SETS, 4, log2(number of sets)
- LOG_WORDS, 2, log2(words per line); TAG_W = ADDR_W - LOG_SETS - LOG_WORDS - 2

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- s_address  in  ADDR_W  CPU byte address; low 2 bits ignored
- s_read  in  1  CPU read request
- s_waitrequest  out  1  stall; the read completes in the cycle this is low
- s_readdata  out  DATA_W  read data, valid when s_read & ~s_waitrequest
- flush  in  1  one-cycle pulse: invalidate all lines
- m_address  out  ADDR_W  line-aligned refill address
- m_read  out  1  refill burst request
- m_burstcount  out  LOG_WORDS+1  constant 2**LOG_WORDS
- m_waitrequest  in  1  memory command stall
- m_readdata  in  DATA_W  refill beat data
- m_readdatavalid  in  1  refill beat strobe

## Operation
- States: IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, RESPOND.
- IDLE: if a flush is pending, clear all valid bits and the pending flag this cycle, then stay in IDLE. Otherwise, if s_read is high, register s_address and go to LOOKUP. A flush takes priority over s_read.
- LOOKUP: compare the registered tag against all WAYS tags of the indexed set, qualified by valid.
  - Hit: drive the hit way's word, s_waitrequest=0, then go to IDLE.
  - Miss: choose the victim and go to REFILL_REQ.
  - Exactly one way can match; a multiple match is a design error, and the bench asserts against it.
- Victim selection: the lowest-index invalid way. If all ways are valid, use the set's round-robin pointer (LOG_WAYS bits per set). The pointer increments modulo WAYS only when it supplied the victim.
- REFILL_REQ: m_read=1, m_address = {tag, index, LOG_WORDS+2 zero bits}, held stable while m_waitrequest=1. On the cycle m_waitrequest=0, go to REFILL_DATA.
- REFILL_DATA: beat counter starts at 0. Each m_readdatavalid writes m_readdata into the victim way at word = counter, and the counter increments. The beat whose counter equals the requested word offset is also captured into a response register. On the last beat (counter = 2**LOG_WORDS-1), write the tag, set valid, and go to RESPOND.
- RESPOND: s_readdata = response register, s_waitrequest=0, then go to IDLE.
- A flush pulse arriving outside IDLE sets the pending flag, which is serviced on the next IDLE cycle. A flush arriving while a refill is in flight does not stop that refill from marking its line valid; the pending flush clears it afterwards.
- s_address is sampled only in IDLE. The CPU must hold s_read and s_address until completion, per Avalon.

## Timing
- Reset values:
  - s_waitrequest=1, s_readdata=0, m_read=0, m_address=0, state=IDLE.
  - All valid bits 0, all round-robin pointers 0, flush-pending 0, beat counter 0.
  - Tag and data arrays are not reset.
- s_waitrequest is 1 in every state except LOOKUP-with-hit and RESPOND. This includes the IDLE cycle in which s_read is first seen.
- Hit latency: request seen in cycle 0, data in cycle 1. Back-to-back hits complete every 2 cycles.
- Miss latency: 1 (IDLE) + 1 (LOOKUP) + (1 + memory command stalls) + beats plus memory latency + 1 (RESPOND).
- m_burstcount is constant. m_read is high only in REFILL_REQ.
- Reset asserted mid-refill returns to IDLE next edge with m_read=0. Beats arriving after reset are ignored; the memory side shares reset_n.

## Test plan
- Cold read 0x0000_0104 with a 1-cycle memory stall and beats 0xA0..0xA3 → one burst, m_address=0x100, burstcount=4; s_readdata=0xA1 when s_waitrequest is low.
- Re-read 0x0000_0108 immediately after → no m_read, s_waitrequest low in cycle 1, data 0xA2.
- Fill 5 distinct tags into set 0 (addresses 0x000, 0x400, 0x800, 0xC00, 0x1000) → ways 0-3 fill in order, and the fifth evicts way 0. A re-read of 0x000 then misses while 0x400 hits.
- Flush pulse during a REFILL_DATA beat → the refill completes and returns data. The next IDLE cycle clears all valid bits, so a re-read of the same address misses.
- reset_n low for 1 cycle mid-burst after 2 beats → m_read=0 and s_waitrequest=1 next cycle. A subsequent read of the same line issues a fresh burst.
- Random address stream against a memory model → every s_readdata matches the model, and no multiple-way hit is ever detected.
